// File: rtl/hilo_muldiv_unit_if.sv
// rtl/hilo_muldiv_unit_if.sv - operand/strobe/result bundle between execute stage and the HI/LO mul/div unit
interface hilo_muldiv_unit_if #(
  parameter int WIDTH = 32
);
  logic             start;
  logic [1:0]       op;
  logic [WIDTH-1:0] rs_data;
  logic [WIDTH-1:0] rt_data;
  logic             hi_we;
  logic             lo_we;
  logic [WIDTH-1:0] wdata;
  logic             busy;
  logic             done;
  logic             div0;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;

  modport master (
    output start, op, rs_data, rt_data, hi_we, lo_we, wdata,
    input  busy, done, div0, hi, lo
  );

  modport slave (
    input  start, op, rs_data, rt_data, hi_we, lo_we, wdata,
    output busy, done, div0, hi, lo
  );
endinterface

// File: rtl/hilo_muldiv_unit.sv
// rtl/hilo_muldiv_unit.sv - iterative MULT/MULTU/DIV/DIVU engine holding HI/LO
// Optional macro MULDIV_DIV0_TRAP_EN: divide-by-zero leaves HI/LO intact and pulses div0.
module hilo_muldiv_unit #(
  parameter int WIDTH = 32
) (
  input logic              clk,
  input logic              rst_n,
  hilo_muldiv_unit_if.slave bus
);
  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST_STEP = CW'(WIDTH - 1);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_MUL   = 2'd1;
  localparam logic [1:0] S_DIV   = 2'd2;
  localparam logic [1:0] S_FIXUP = 2'd3;

  logic [1:0]         state;
  logic [CW-1:0]      count;
  logic               loaded;
  logic [WIDTH-1:0]   mag_a;
  logic [WIDTH-1:0]   mag_b;
  logic               neg_prod;
  logic               neg_rem;
  logic               is_div;
  logic               b_zero;
  logic [2*WIDTH-1:0] acc;
  logic [WIDTH-1:0]   hi_q;
  logic [WIDTH-1:0]   lo_q;
  logic               busy_q;
  logic               done_q;

  logic               a_neg;
  logic               b_neg;
  logic [WIDTH:0]     mul_sum;
  logic [WIDTH:0]     div_diff;
  logic [2*WIDTH-1:0] mul_next;
  logic [2*WIDTH-1:0] div_next;
  logic [2*WIDTH-1:0] prod_fix;
  logic [WIDTH-1:0]   quo_fix;
  logic [WIDTH-1:0]   rem_fix;

  assign a_neg = ~bus.op[0] & bus.rs_data[WIDTH-1];
  assign b_neg = ~bus.op[0] & bus.rt_data[WIDTH-1];

  // Multiply: acc = {partial, multiplier}; add multiplicand on lsb, shift right with carry.
  assign mul_sum  = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, mag_a} : {(WIDTH+1){1'b0}});
  assign mul_next = {mul_sum, acc[WIDTH-1:1]};

  // Divide: acc = {remainder, dividend/quotient}; restoring trial subtract on the shifted remainder.
  assign div_diff = acc[2*WIDTH-1:WIDTH-1] - {1'b0, mag_b};
  assign div_next = div_diff[WIDTH] ? {acc[2*WIDTH-2:0], 1'b0}
                                    : {div_diff[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};

  assign prod_fix = neg_prod ? -acc : acc;
  assign quo_fix  = neg_prod ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
  assign rem_fix  = neg_rem ? -acc[2*WIDTH-1:WIDTH] : acc[2*WIDTH-1:WIDTH];

`ifdef MULDIV_DIV0_TRAP_EN
  logic div0_q;
  assign bus.div0 = div0_q;
`else
  assign bus.div0 = 1'b0;
`endif

  assign bus.busy = busy_q;
  assign bus.done = done_q;
  assign bus.hi   = hi_q;
  assign bus.lo   = lo_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= S_IDLE;
      count    <= '0;
      loaded   <= 1'b0;
      mag_a    <= '0;
      mag_b    <= '0;
      neg_prod <= 1'b0;
      neg_rem  <= 1'b0;
      is_div   <= 1'b0;
      b_zero   <= 1'b0;
      acc      <= '0;
      hi_q     <= '0;
      lo_q     <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
`ifdef MULDIV_DIV0_TRAP_EN
      div0_q   <= 1'b0;
`endif
    end else begin
      done_q <= 1'b0;
`ifdef MULDIV_DIV0_TRAP_EN
      div0_q <= 1'b0;
`endif
      case (state)
        S_IDLE: begin
          if (bus.start) begin
            mag_a    <= a_neg ? -bus.rs_data : bus.rs_data;
            mag_b    <= b_neg ? -bus.rt_data : bus.rt_data;
            neg_prod <= a_neg ^ b_neg;
            neg_rem  <= a_neg;
            is_div   <= bus.op[1];
            b_zero   <= (bus.rt_data == '0);
            count    <= '0;
            loaded   <= 1'b0;
            state    <= bus.op[1] ? S_DIV : S_MUL;
          end else begin
            if (bus.hi_we) hi_q <= bus.wdata;
            if (bus.lo_we) lo_q <= bus.wdata;
          end
        end
        S_MUL, S_DIV: begin
          // First cycle seeds the accumulator from the latched magnitudes; busy rises here.
          if (!loaded) begin
            loaded <= 1'b1;
            busy_q <= 1'b1;
            acc    <= is_div ? {{WIDTH{1'b0}}, mag_a} : {{WIDTH{1'b0}}, mag_b};
          end else begin
            acc   <= (state == S_DIV) ? div_next : mul_next;
            count <= count + 1'b1;
            if (count == LAST_STEP) state <= S_FIXUP;
          end
        end
        S_FIXUP: begin
          state  <= S_IDLE;
          busy_q <= 1'b0;
          done_q <= 1'b1;
          if (!is_div) begin
            {hi_q, lo_q} <= prod_fix;
          end else begin
`ifdef MULDIV_DIV0_TRAP_EN
            if (b_zero) begin
              div0_q <= 1'b1;
            end else begin
              hi_q <= rem_fix;
              lo_q <= quo_fix;
            end
`else
            // Zero divisor: the restoring loop leaves the dividend as remainder; force all-ones quotient.
            hi_q <= rem_fix;
            lo_q <= b_zero ? {WIDTH{1'b1}} : quo_fix;
`endif
          end
        end
      endcase
    end
  end
endmodule

// File: tb/tb_hilo_muldiv_unit.sv
// tb/tb_hilo_muldiv_unit.sv - scoreboard bench for hilo_muldiv_unit
module tb_hilo_muldiv_unit;
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  hilo_muldiv_unit_if #(.WIDTH(32)) bus ();

  hilo_muldiv_unit #(.WIDTH(32)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int          n_cmp = 0;
  int          n_bad = 0;
  int unsigned edge_cnt = 0;
  int unsigned start_edge = 0;
  logic [31:0] m_hi = '0;
  logic [31:0] m_lo = '0;
  logic [64:0] exp_q[$];

  always @(posedge clk) edge_cnt <= edge_cnt + 1;

  task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [64:0] model(input logic [1:0] op, input logic [31:0] rs, input logic [31:0] rt);
    longint      sa, sb, q, r;
    logic [63:0] p, qq, rr;
    sa = longint'($signed(rs));
    sb = longint'($signed(rt));
    model = {1'b0, m_hi, m_lo};
    case (op)
      2'd0: begin p = sa * sb; model = {1'b0, p}; end
      2'd1: begin p = {32'b0, rs} * {32'b0, rt}; model = {1'b0, p}; end
      default: begin
        if (rt == 32'd0) begin
`ifdef MULDIV_DIV0_TRAP_EN
          model = {1'b1, m_hi, m_lo};
`else
          model = {1'b0, rs, 32'hFFFF_FFFF};
`endif
        end else if (op == 2'd2) begin
          q = sa / sb;
          r = sa % sb;
          qq = q;
          rr = r;
          model = {1'b0, rr[31:0], qq[31:0]};
        end else begin
          model = {1'b0, rs % rt, rs / rt};
        end
      end
    endcase
  endfunction

  task automatic start_op(input logic [1:0] op, input logic [31:0] rs, input logic [31:0] rt, input bit push);
    logic [64:0] e;
    bus.op      = op;
    bus.rs_data = rs;
    bus.rt_data = rt;
    bus.start   = 1'b1;
    if (push) begin
      e = model(op, rs, rt);
      exp_q.push_back(e);
      m_hi = e[63:32];
      m_lo = e[31:0];
    end
    @(posedge clk);
    #1;
    bus.start  = 1'b0;
    start_edge = edge_cnt;
  endtask

  task automatic finish_op(input string tag);
    int          bcnt = 0;
    bit          seen = 0;
    logic [64:0] e;
    for (int i = 0; i < 60 && !seen; i++) begin
      @(negedge clk);
      if (bus.done) seen = 1;
      else if (bus.busy) bcnt++;
    end
    check_val({tag, " done_seen"}, 64'(seen), 64'd1);
    if (seen) begin
      check_val({tag, " latency"}, 64'(edge_cnt - start_edge), 64'd34);
      check_val({tag, " busy_cycles"}, 64'(bcnt), 64'd33);
      check_val({tag, " busy_in_done"}, 64'(bus.busy), 64'd0);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check_val({tag, " hi"}, 64'(bus.hi), 64'(e[63:32]));
        check_val({tag, " lo"}, 64'(bus.lo), 64'(e[31:0]));
        check_val({tag, " div0"}, 64'(bus.div0), 64'(e[64]));
      end
    end
  endtask

  task automatic write_hilo(input logic hw, input logic lw, input logic [31:0] d);
    bus.hi_we = hw;
    bus.lo_we = lw;
    bus.wdata = d;
    @(posedge clk);
    #1;
    bus.hi_we = 1'b0;
    bus.lo_we = 1'b0;
    if (hw) m_hi = d;
    if (lw) m_lo = d;
  endtask

  initial begin
    bit          late_done;
    logic [1:0]  rop;
    logic [31:0] rrs, rrt;

    rst_n       = 1'b0;
    bus.start   = 1'b0;
    bus.op      = 2'd0;
    bus.rs_data = '0;
    bus.rt_data = '0;
    bus.hi_we   = 1'b0;
    bus.lo_we   = 1'b0;
    bus.wdata   = '0;
    repeat (3) @(posedge clk);
    #1;
    check_val("reset hi", 64'(bus.hi), 64'd0);
    check_val("reset lo", 64'(bus.lo), 64'd0);
    check_val("reset busy", 64'(bus.busy), 64'd0);
    check_val("reset done", 64'(bus.done), 64'd0);
    check_val("reset div0", 64'(bus.div0), 64'd0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    start_op(2'd0, 32'hFFFF_FFFD, 32'd7, 1);
    finish_op("mult_neg3x7");

    start_op(2'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1);
    finish_op("multu_max");
    start_op(2'd3, 32'd100, 32'd7, 1);
    finish_op("divu_b2b");

    start_op(2'd2, 32'hFFFF_FFF9, 32'd2, 1);
    finish_op("div_neg7_2");
    start_op(2'd2, 32'h8000_0000, 32'hFFFF_FFFF, 1);
    finish_op("div_ovf");

    write_hilo(1'b1, 1'b1, 32'h1234);
    check_val("mthi_mtlo hi", 64'(bus.hi), 64'h1234);
    check_val("mthi_mtlo lo", 64'(bus.lo), 64'h1234);
    start_op(2'd3, 32'd5, 32'd0, 1);
    finish_op("divu_by0");

    bus.hi_we = 1'b1;
    bus.wdata = 32'hBB;
    start_op(2'd0, 32'd3, 32'd4, 1);
    bus.hi_we = 1'b0;
    fork
      finish_op("mult_ignore");
      begin
        repeat (9) @(posedge clk);
        #1;
        bus.start   = 1'b1;
        bus.op      = 2'd2;
        bus.rs_data = 32'd99;
        bus.rt_data = 32'd5;
        bus.hi_we   = 1'b1;
        bus.wdata   = 32'hAA;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        bus.hi_we = 1'b0;
      end
    join

    for (int k = 0; k < 12; k++) begin
      rop = 2'(k % 4);
      rrs = (k == 5) ? 32'h8000_0000 : $urandom;
      rrt = ($urandom_range(0, 5) == 0) ? 32'd0 : $urandom;
      if (k[0]) rrt = rrt >> $urandom_range(0, 28);
      start_op(rop, rrs, rrt, 1);
      finish_op($sformatf("rand%0d_op%0d", k, rop));
    end

    write_hilo(1'b1, 1'b1, 32'hDEAD_BEEF);
    start_op(2'd0, 32'd123, 32'd456, 0);
    repeat (14) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    check_val("midop_reset busy", 64'(bus.busy), 64'd0);
    check_val("midop_reset hi", 64'(bus.hi), 64'd0);
    check_val("midop_reset lo", 64'(bus.lo), 64'd0);
    m_hi = '0;
    m_lo = '0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    late_done = 0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (bus.done) late_done = 1;
    end
    check_val("no_done_after_reset", 64'(late_done), 64'd0);
    write_hilo(1'b0, 1'b1, 32'h55);
    check_val("mtlo_after_reset lo", 64'(bus.lo), 64'h55);
    check_val("mtlo_after_reset hi", 64'(bus.hi), 64'h0);
    check_val("scoreboard_empty", 64'(exp_q.size()), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
